// File: rtl/subtractor.sv
// Two-stage pipelined 32-bit unsigned subtractor: low half and its borrow in stage 1,
// high half with that borrow applied in stage 2; valid/ready on both sides, 2 ops in flight.
module subtractor (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        borrow,
   output logic        zero,
   output logic [15:0] res_cnt
);

   logic        s1_v;
   logic [15:0] s1_lo;
   logic        s1_b;
   logic [15:0] s1_a;
   logic [15:0] s1_c;
   logic        s2_v;

   logic        s2_ready;
   logic        s1_adv;
   logic        in_xfer;
   logic        out_xfer;
   logic [16:0] lo_diff;
   logic [16:0] hi_diff;

   assign s2_ready  = !s2_v || out_ready;
   assign s1_adv    = s1_v && s2_ready;
   // Combinational from out_ready: a draining stage 2 frees a slot in the same cycle.
   assign in_ready  = !s1_v || s2_ready;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = s2_v && out_ready;
   assign out_valid = s2_v;

   // The MSB of each 17-bit difference is the borrow out of that half.
   assign lo_diff = {1'b0, in1[15:0]} - {1'b0, in2[15:0]};
   assign hi_diff = {1'b0, s1_a} - {1'b0, s1_c} - {16'd0, s1_b};

   // rst_n is active-high here, matching the surrounding codebase.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s1_v    <= 1'b0;
         s1_lo   <= 16'd0;
         s1_b    <= 1'b0;
         s1_a    <= 16'd0;
         s1_c    <= 16'd0;
         s2_v    <= 1'b0;
         out     <= 32'd0;
         borrow  <= 1'b0;
         zero    <= 1'b0;
         res_cnt <= 16'd0;
      end else begin
         if (in_xfer) begin
            s1_v  <= 1'b1;
            s1_lo <= lo_diff[15:0];
            s1_b  <= lo_diff[16];
            s1_a  <= in1[31:16];
            s1_c  <= in2[31:16];
         end else if (s1_adv) begin
            s1_v <= 1'b0;
         end

         if (s1_adv) begin
            s2_v   <= 1'b1;
            out    <= {hi_diff[15:0], s1_lo};
            borrow <= hi_diff[16];
            zero   <= (s1_lo == 16'd0) && (hi_diff[15:0] == 16'd0);
         end else if (out_xfer) begin
            s2_v <= 1'b0;
         end

         if (out_xfer) begin
            res_cnt <= res_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_subtractor.sv
// Scoreboard bench for subtractor: driver pushes expected results, a negedge monitor
// pops and compares on every output transfer and tracks the result count.
module tb_subtractor;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        borrow;
   logic        zero;
   logic [15:0] res_cnt;

   subtractor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .borrow    (borrow),
      .zero      (zero),
      .res_cnt   (res_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // {out, borrow, zero}
   logic [33:0] exp_q[$];
   logic [15:0] exp_cnt;

   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      d = a - b;
      return {d, (a < b), (d == 32'd0)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: compares at the negedge before the edge on which the transfer happens.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_cnt = 16'd0;
      end else if (out_valid && out_ready) begin
         chk("res_cnt_before_xfer", {16'd0, res_cnt}, {16'd0, exp_cnt});
         exp_cnt = exp_cnt + 16'd1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got 0x%08h expected none", out);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            chk("out", out, e[33:2]);
            chk("borrow", {31'd0, borrow}, {31'd0, e[1]});
            chk("zero", {31'd0, zero}, {31'd0, e[0]});
         end
      end
   end

   // Called at posedge+1; offers one pair for up to max_cyc cycles.
   task automatic offer(input logic [31:0] a, input logic [31:0] b, input int max_cyc,
                        output bit ok);
      in1      = a;
      in2      = b;
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            exp_q.push_back(model(a, b));
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      exp_q.delete();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_res_cnt", {16'd0, res_cnt}, 32'd0);
      chk("rst_out", out, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      logic [31:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in1       = 32'd0;
      in2       = 32'd0;
      out_ready = 1'b1;
      exp_cnt   = 16'd0;
      #3;
      do_reset();

      // Single op with cross-half borrow; result appears after the second edge.
      offer(32'h0001_0000, 32'h0000_0001, 4, ok);
      chk("single_accept", {31'd0, ok}, 32'd1);
      @(negedge clk);
      chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_out", out, 32'h0000_FFFF);
      drain();
      chk("cnt_after_single", {16'd0, res_cnt}, 32'd1);

      // Hand-computed directed vectors.
      offer(32'h0000_0000, 32'h0000_0001, 4, ok);
      offer(32'h1234_5678, 32'h1234_5678, 4, ok);
      offer(32'hFFFF_FFFF, 32'h0000_0001, 4, ok);
      offer(32'h8000_0000, 32'h0000_8000, 4, ok);
      drain();
      chk("cnt_after_directed", {16'd0, res_cnt}, 32'd5);

      // Streaming: in_ready must never drop with out_ready held high.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         offer($urandom, $urandom, 1, ok);
         chk("stream_accept", {31'd0, ok}, 32'd1);
      end
      drain();
      chk("cnt_after_stream", {16'd0, res_cnt}, 32'd100);

      // Backpressure: 2 accepted, third refused, output held stable.
      do_reset();
      out_ready = 1'b0;
      offer(32'h0000_0010, 32'h0000_0003, 1, ok);
      chk("bp_acc1", {31'd0, ok}, 32'd1);
      offer(32'h0000_0003, 32'h0000_0010, 1, ok);
      chk("bp_acc2", {31'd0, ok}, 32'd1);
      offer(32'hABCD_0000, 32'h0000_ABCD, 4, ok);
      chk("bp_refuse3", {31'd0, ok}, 32'd0);
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      held = out;
      chk("bp_out_first", held, 32'h0000_000D);
      repeat (3) @(negedge clk);
      chk("bp_out_stable", out, held);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      offer(32'hABCD_0000, 32'h0000_ABCD, 2, ok);
      chk("bp_acc3", {31'd0, ok}, 32'd1);
      drain();
      chk("cnt_after_bp", {16'd0, res_cnt}, 32'd3);

      // Reset with two ops in flight discards them.
      out_ready = 1'b0;
      offer(32'h0000_0005, 32'h0000_0001, 1, ok);
      offer(32'h0000_0006, 32'h0000_0001, 1, ok);
      do_reset();
      out_ready = 1'b1;
      offer(32'h0000_0100, 32'h0000_0001, 4, ok);
      drain();
      chk("cnt_after_midreset", {16'd0, res_cnt}, 32'd1);

      // Counter wrap: 65537 transfers leave res_cnt at 1.
      do_reset();
      for (int i = 0; i < 65537; i++) begin
         offer(i, 32'd7, 1, ok);
         if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wrap_accept: got 0 expected 1 at %0d", i);
         end
      end
      drain();
      chk("cnt_wrap", {16'd0, res_cnt}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
